// File: rtl/rf80386_ifetch_buf.sv
// Two-line (2 x 16 B) instruction prefetch buffer for the 80386 front end.
// Latency: ihit_o/ibundle_o combinational from line state; a miss refills over mem_req_o/mem_ack_i.
// Backpressure: level request held until a one-cycle ack; re-issued after BUS_TIMEOUT idle cycles.
// Optional macro RF80386_IFB_MISS_COUNT_EN enables the miss_count_o episode counter.
module rf80386_ifetch_buf #(
  parameter int BUS_TIMEOUT = 31
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [31:0]  csip_i,
  input  logic         inv_i,
  output logic [127:0] ibundle_o,
  output logic         ihit_o,
  output logic         mem_req_o,
  output logic [31:0]  mem_adr_o,
  input  logic         mem_ack_i,
  input  logic [127:0] mem_dat_i,
  output logic [31:0]  miss_count_o
);

  localparam int CW = $clog2(BUS_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, REQ0, REQ1} state_t;

  state_t         state;
  logic [127:0]   l0_dat, l1_dat;
  logic [27:0]    l0_tag, l1_tag;
  logic           l0_v, l1_v;
  logic           discard;
  logic [CW-1:0]  to_cnt;

  logic           in_req, ack_ok, do_write, hit_raw, seq_hit, wr_l0, wr_l1, do_shift;
  logic [7:0]     pair_b [32];

  // L1 always follows L0, so only the L0 tag is stored; the add wraps naturally.
  assign l1_tag   = l0_tag + 28'd1;
  assign in_req   = (state == REQ0) || (state == REQ1);
  assign ack_ok   = in_req & mem_req_o & mem_ack_i;
  assign do_write = ack_ok & ~inv_i & ~discard;
  assign wr_l0    = do_write & (state == REQ0);
  assign wr_l1    = do_write & (state == REQ1);
  assign do_shift = (state == SHIFT) & ~inv_i;
  assign hit_raw  = l0_v & l1_v & (l0_tag == csip_i[31:4]);
  assign seq_hit  = l1_v & (l1_tag == csip_i[31:4]);
  assign ihit_o   = hit_raw & ~inv_i;

  // Flatten both lines into a 32-byte window indexed from L0 byte 0.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      pair_b[i]      = l0_dat[8*i +: 8];
      pair_b[i + 16] = l1_dat[8*i +: 8];
    end
  end

  // Bundle is the 16 bytes starting at the csip offset within L0.
  always_comb begin
    ibundle_o = '0;
    for (int i = 0; i < 16; i++) begin
      ibundle_o[8*i +: 8] = pair_b[5'(i) + {1'b0, csip_i[3:0]}];
    end
  end

  // Line data is not reset; valid bits alone qualify it.
  always_ff @(posedge clk_i) begin
    if (wr_l0)    l0_dat <= mem_dat_i;
    if (do_shift) l0_dat <= l1_dat;
    if (wr_l1)    l1_dat <= mem_dat_i;
  end

  // Control FSM: hit/shift/refill decisions, bus request and timeout handling.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= IDLE;
      l0_tag    <= '0;
      l0_v      <= 1'b0;
      l1_v      <= 1'b0;
      discard   <= 1'b0;
      to_cnt    <= '0;
      mem_req_o <= 1'b0;
      mem_adr_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inv_i) begin
            l0_v <= 1'b0;
            l1_v <= 1'b0;
          end else if (!hit_raw) begin
            if (seq_hit) begin
              state <= SHIFT;
            end else begin
              l0_tag <= csip_i[31:4];
              l0_v   <= 1'b0;
              l1_v   <= 1'b0;
              state  <= REQ0;
            end
          end
        end
        SHIFT: begin
          if (inv_i) begin
            l0_v  <= 1'b0;
            l1_v  <= 1'b0;
            state <= IDLE;
          end else begin
            l0_tag <= l1_tag;
            l0_v   <= l1_v;
            l1_v   <= 1'b0;
            state  <= REQ1;
          end
        end
        REQ0, REQ1: begin
          if (!mem_req_o) begin
            // Request is raised one cycle after entry or after a timeout drop.
            mem_req_o <= 1'b1;
            mem_adr_o <= {(state == REQ0) ? l0_tag : l1_tag, 4'h0};
            to_cnt    <= '0;
          end else if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            to_cnt    <= '0;
            if (inv_i || discard) begin
              // Stale transfer: swallow the ack and re-evaluate from IDLE.
              discard <= 1'b0;
              l0_v    <= 1'b0;
              l1_v    <= 1'b0;
              state   <= IDLE;
            end else if (state == REQ0) begin
              l0_v  <= 1'b1;
              state <= l1_v ? IDLE : REQ1;
            end else begin
              l1_v  <= 1'b1;
              state <= IDLE;
            end
          end else if (to_cnt == CW'(BUS_TIMEOUT - 1)) begin
            mem_req_o <= 1'b0;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + CW'(1);
          end
          if (inv_i && !ack_ok) begin
            l0_v    <= 1'b0;
            l1_v    <= 1'b0;
            discard <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef RF80386_IFB_MISS_COUNT_EN
  logic        miss_start;
  logic [31:0] miss_cnt;

  assign miss_start   = (state == IDLE) & ~inv_i & ~hit_raw;
  assign miss_count_o = miss_cnt;

  // One increment per IDLE->REQ0 or IDLE->SHIFT transition.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) miss_cnt <= '0;
    else if (miss_start) miss_cnt <= miss_cnt + 32'd1;
  end
`else
  assign miss_count_o = '0;
`endif

endmodule

// File: tb/tb_rf80386_ifetch_buf.sv
module tb_rf80386_ifetch_buf;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [31:0]  csip_i = '0;
  logic         inv_i = 1'b0;
  logic [127:0] ibundle_o;
  logic         ihit_o;
  logic         mem_req_o;
  logic [31:0]  mem_adr_o;
  logic         mem_ack_i = 1'b0;
  logic [127:0] mem_dat_i = '0;
  logic [31:0]  miss_count_o;

  int checks = 0;
  int failures = 0;
  int exp_miss = 0;

`ifdef RF80386_IFB_MISS_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  rf80386_ifetch_buf #(.BUS_TIMEOUT(31)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .csip_i(csip_i), .inv_i(inv_i),
    .ibundle_o(ibundle_o), .ihit_o(ihit_o), .mem_req_o(mem_req_o),
    .mem_adr_o(mem_adr_o), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i),
    .miss_count_o(miss_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Memory image: byte n of line a = (a[7:0]+n) ^ a[15:8] ^ 8'h5A
  function automatic logic [127:0] line(input logic [31:0] a);
    logic [127:0] r;
    for (int n = 0; n < 16; n++) r[8*n +: 8] = (a[7:0] + 8'(n)) ^ a[15:8] ^ 8'h5A;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_miss(input string tag);
    chk(tag, {96'd0, miss_count_o}, CNT_EN ? 128'(exp_miss) : 128'd0);
  endtask

  // Wait (bounded) for a request, check its address, ack after dly cycles.
  task automatic serve(input logic [31:0] a, input int dly, input logic [127:0] d);
    int n = 0;
    while (mem_req_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk($sformatf("req_seen@%h", a), {127'd0, mem_req_o}, 128'd1);
    chk($sformatf("req_adr@%h", a), {96'd0, mem_adr_o}, {96'd0, a});
    repeat (dly) tick();
    mem_dat_i = d;
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
  endtask

  initial begin
    int n;
    // Reset state
    tick();
    chk("rst_req", {127'd0, mem_req_o}, 128'd0);
    chk("rst_adr", {96'd0, mem_adr_o}, 128'd0);
    chk("rst_hit", {127'd0, ihit_o}, 128'd0);
    chk("rst_miss", {96'd0, miss_count_o}, 128'd0);

    // Cold miss at FFFF0000
    csip_i = 32'hFFFF0000;
    rst_ni = 1'b1;
    exp_miss = 1;
    serve(32'hFFFF0000, 3, line(32'hFFFF0000));
    chk("cold_hit_mid", {127'd0, ihit_o}, 128'd0);
    serve(32'hFFFF0010, 3, line(32'hFFFF0010));
    chk("cold_hit", {127'd0, ihit_o}, 128'd1);
    chk("cold_b0", {120'd0, ibundle_o[7:0]}, 128'h5A);
    chk_miss("cold_miss_cnt");

    // Straddle at 0x10E
    csip_i = 32'h0000010E;
    exp_miss++;
    serve(32'h100, 1, line(32'h100));
    serve(32'h110, 0, line(32'h110));
    chk("strad_hit", {127'd0, ihit_o}, 128'd1);
    chk("strad_lo", {112'd0, ibundle_o[15:0]}, 128'h5455);
    chk("strad_l1b0", {120'd0, ibundle_o[23:16]}, 128'h4B);

    // Sequential shift 0x10F -> 0x110
    csip_i = 32'h0000010F;
    #1;
    chk("seq_hit10f", {127'd0, ihit_o}, 128'd1);
    chk("seq_b0_10f", {112'd0, ibundle_o[15:0]}, 128'h4B54);
    csip_i = 32'h00000110;
    #1;
    chk("seq_miss110", {127'd0, ihit_o}, 128'd0);
    exp_miss++;
    serve(32'h120, 1, line(32'h120));
    chk("seq_hit", {127'd0, ihit_o}, 128'd1);
    chk("seq_bundle", ibundle_o, line(32'h110));
    csip_i = 32'h0000011F;
    #1;
    chk("seq_strad", {112'd0, ibundle_o[15:0]}, 128'h7B44);
    chk_miss("seq_miss_cnt");

    // Timeout and re-issue at 0x200
    csip_i = 32'h00000200;
    exp_miss++;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 20) begin tick(); n++; end
    chk("to_first_adr", {96'd0, mem_adr_o}, 128'h200);
    n = 0;
    while (mem_req_o === 1'b1 && n < 40) begin n++; tick(); end
    chk("to_high_cycles", 128'(n), 128'd31);
    chk("to_drop", {127'd0, mem_req_o}, 128'd0);
    tick();
    chk("to_reissue", {127'd0, mem_req_o}, 128'd1);
    serve(32'h200, 2, line(32'h200));
    serve(32'h210, 0, line(32'h210));
    chk("to_hit", {127'd0, ihit_o}, 128'd1);
    chk_miss("to_miss_cnt");

    // Invalidate during REQ0, ack two cycles later is discarded
    csip_i = 32'h00000300;
    exp_miss++;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 20) begin tick(); n++; end
    chk("inv_adr", {96'd0, mem_adr_o}, 128'h300);
    inv_i = 1'b1;
    tick();
    inv_i = 1'b0;
    tick();
    mem_dat_i = ~line(32'h300);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    chk("inv_hit", {127'd0, ihit_o}, 128'd0);
    chk("inv_req_drop", {127'd0, mem_req_o}, 128'd0);
    exp_miss++;
    serve(32'h300, 0, line(32'h300));
    serve(32'h310, 0, line(32'h310));
    chk("inv_refetch", ibundle_o, line(32'h300));
    chk_miss("inv_miss_cnt");

    // Wrap across the top of the address space
    csip_i = 32'hFFFFFFF8;
    exp_miss++;
    serve(32'hFFFFFFF0, 1, line(32'hFFFFFFF0));
    serve(32'h00000000, 1, line(32'h00000000));
    chk("wrap_hit", {127'd0, ihit_o}, 128'd1);
    chk("wrap_b8", {120'd0, ibundle_o[71:64]}, 128'h5A);
    chk("wrap_b0", {120'd0, ibundle_o[7:0]}, 128'h5D);

    // Invalidate in IDLE while hitting
    inv_i = 1'b1;
    #1;
    chk("idle_inv_comb", {127'd0, ihit_o}, 128'd0);
    tick();
    inv_i = 1'b0;
    #1;
    chk("idle_inv_clear", {127'd0, ihit_o}, 128'd0);
    exp_miss++;
    serve(32'hFFFFFFF0, 0, line(32'hFFFFFFF0));
    serve(32'h00000000, 0, line(32'h00000000));
    chk("idle_inv_refill", {127'd0, ihit_o}, 128'd1);

    // Reset mid-transfer, late ack ignored
    csip_i = 32'h00000400;
    n = 0;
    while (mem_req_o !== 1'b1 && n < 20) begin tick(); n++; end
    rst_ni = 1'b0;
    #1;
    chk("mrst_req", {127'd0, mem_req_o}, 128'd0);
    chk("mrst_adr", {96'd0, mem_adr_o}, 128'd0);
    chk("mrst_hit", {127'd0, ihit_o}, 128'd0);
    chk("mrst_miss", {96'd0, miss_count_o}, 128'd0);
    tick();
    rst_ni = 1'b1;
    mem_dat_i = ~line(32'h400);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    exp_miss = 1;
    serve(32'h400, 0, line(32'h400));
    serve(32'h410, 0, line(32'h410));
    chk("mrst_bundle", ibundle_o, line(32'h400));
    chk_miss("mrst_miss_cnt");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf80386_ifetch_buf.md
RF80386_IFETCH_BUF -- requirements
Module: rf80386_ifetch_buf

Interface
REQ-001 SHALL have parameter BUS_TIMEOUT, default 31: cycles to wait for mem_ack_i before re-issuing a read.
REQ-002 SHALL have port clk_i  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port csip_i  input  32  linear fetch address from the CPU (cs base + eip).
REQ-005 SHALL have port inv_i  input  1  invalidate both lines (self-modifying code, far jump).
REQ-006 SHALL have port ibundle_o  output  128  16 instruction bytes starting at csip_i, byte 0 in bits [7:0].
REQ-007 SHALL have port ihit_o  output  1  ibundle_o valid for the current csip_i.
REQ-008 SHALL have port mem_req_o  output  1  line read request, level, held until ack.
REQ-009 SHALL have port mem_adr_o  output  32  line address, bits [3:0] always 0.
REQ-010 SHALL have port mem_ack_i  input  1  one-cycle acknowledge; mem_dat_i valid the same cycle.
REQ-011 SHALL have port mem_dat_i  input  128  line data, byte n in bits [8n+7:8n].
REQ-012 SHALL have port miss_count_o  output  32  number of miss episodes (see Configuration).

Function
REQ-013 SHALL hold two 16-byte lines, L0 and L1, each with a 28-bit tag and a valid bit; L1 tag is always L0 tag + 1 (mod 2^28).
REQ-014 SHALL drive ihit_o combinationally = L0.v & L1.v & (L0.tag == csip_i[31:4]) & ~inv_i.
REQ-015 SHALL drive ibundle_o = bits [127:0] of ({L1,L0} >> (8*csip_i[3:0])), regardless of ihit_o.
REQ-016 SHALL implement FSM states IDLE, SHIFT, REQ0, REQ1, with transitions evaluated each cycle.
REQ-017 In IDLE on a hit: no action.
REQ-018 In IDLE, if L1.v and csip_i[31:4] == L1.tag: go to SHIFT.
REQ-019 In IDLE, on any other miss: set L0.tag = csip_i[31:4], clear both valid bits, and go to REQ0.
REQ-020 SHIFT, one cycle: L0 <= L1 (data, tag, valid); L1.tag <= L1.tag + 1; L1.v <= 0; go to REQ1.
REQ-021 REQ0/REQ1: assert mem_req_o with mem_adr_o = {tag,4'h0} of L0/L1.
REQ-022 REQ0/REQ1: on mem_ack_i, write mem_dat_i into the line, set its valid bit, and deassert mem_req_o the next cycle.
REQ-023 After REQ0 completes: go to REQ1 if L1.v = 0, otherwise IDLE.
REQ-024 After REQ1 completes: go to IDLE.
REQ-025 ihit_o SHALL rise exactly one cycle after the final ack of a miss, given csip_i stable.
REQ-026 SHALL count cycles in REQ0/REQ1 without ack; at BUS_TIMEOUT, drop mem_req_o for one cycle, then re-issue the same address with the counter cleared.
REQ-027 SHALL ignore mem_ack_i outside REQ0/REQ1.
REQ-028 inv_i in IDLE or SHIFT: clear both valid bits next cycle and go to IDLE.
REQ-029 inv_i in REQ0/REQ1: clear both valid bits and set a discard flag.
REQ-030 While the discard flag is set, the pending ack SHALL be consumed without writing data, then go to IDLE and clear the flag.
REQ-031 inv_i takes priority over a same-cycle mem_ack_i write.
REQ-032 csip_i changes during REQ0/REQ1 SHALL NOT abort the transfer; the miss is re-evaluated in IDLE.
REQ-033 L1 tag arithmetic SHALL wrap: L0.tag = 28'hFFFFFFF gives L1.tag = 0.

Reset
REQ-034 On rst_ni low, asynchronously: state = IDLE, valid bits = 0, tags = 0, discard = 0, timeout counter = 0, mem_req_o = 0, mem_adr_o = 0, miss_count_o = 0.
REQ-035 Line data registers SHALL NOT be reset; ihit_o = 0 and ibundle_o is don't-care while invalid.
REQ-036 Reset asserted mid-transfer SHALL abandon it; a late ack after reset release is ignored per REQ-027.

Configuration
REQ-037 With macro RF80386_IFB_MISS_COUNT_EN defined: miss_count_o increments (wrapping) once on each IDLE->REQ0 or IDLE->SHIFT transition.
REQ-038 Without RF80386_IFB_MISS_COUNT_EN: miss_count_o is constant 0 and no counter register exists.

Verification
REQ-039 Cold miss: reset, csip_i=32'hFFFF0000, acks after 3 cycles -> reads at FFFF0000 then FFFF0010; ihit_o=1 one cycle after the second ack; ibundle_o[7:0] = byte 0 of the first line.
REQ-040 Straddle: lines loaded at 0x100/0x110, csip_i=0x10E -> ibundle_o[15:0] = line0 bytes E,F; ibundle_o[23:16] = line1 byte 0.
REQ-041 Sequential shift: csip_i moves 0x10F->0x110 -> SHIFT, single read of 0x120, no read of 0x110; miss_count_o +1 with the macro defined.
REQ-042 Timeout: no ack for BUS_TIMEOUT=31 cycles -> mem_req_o low one cycle, then the same mem_adr_o is re-requested; a later ack completes normally.
REQ-043 Invalidate mid-fetch: inv_i pulse in REQ0, ack two cycles later -> data discarded, state IDLE, ihit_o=0, new miss fetch starts.
REQ-044 Wrap: csip_i=32'hFFFFFFF8 -> reads FFFFFFF0 then 00000000; ibundle_o[71:64] = byte 0 of address 0.
